// File: rtl/afifo_pkg.sv
// -----------------------------------------------------------------------------
// afifo_pkg
// Shared definitions for the asynchronous FIFO read and write controllers.
//   DATASIZE_DEF / ADDRSIZE_DEF : default word width and RAM address width
//   DEPTH                       : number of RAM words for the default size
//   ptr_t / data_t              : pointer (ADDRSIZE+1 bits) and word types
//   bin2gray / gray2bin         : code conversions on a 32-bit container.
//                                 Narrower pointers are zero-extended on the
//                                 way in and truncated on the way out. This is
//                                 exact because the unused upper bits stay zero
//                                 in both codes.
// -----------------------------------------------------------------------------
package afifo_pkg;

    localparam int DATASIZE_DEF = 8;
    localparam int ADDRSIZE_DEF = 4;
    localparam int DEPTH        = 1 << ADDRSIZE_DEF;

    typedef logic [ADDRSIZE_DEF:0]   ptr_t;
    typedef logic [DATASIZE_DEF-1:0] data_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/afifo_sync_w2r.sv
// -----------------------------------------------------------------------------
// afifo_sync_w2r
// Generic two-flop synchroniser for a Gray-coded pointer crossing into the
// local clock domain. The write side reuses it in the opposite direction.
//   clk    : destination-domain clock
//   rst    : asynchronous, active-high reset; both stages clear to 0
//   d_i    : pointer from the foreign clock domain
//   q_o    : pointer after two destination-domain flops
// -----------------------------------------------------------------------------
module afifo_sync_w2r #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // No logic is placed between the two stages. The first stage may go
    // metastable, so it gets a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make both stages sample pre-edge
            // values. Blocking here would collapse the chain into one flop.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/afifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// afifo_rd_ctrl
// Read-domain half of the asynchronous FIFO. It owns the binary and Gray read
// pointers, synchronises the write Gray pointer into rclk, and produces the
// empty flag and a pessimistic fill count. It addresses the dual-port RAM and
// returns registered read data with a valid strobe.
//   rclk, rrst   : read clock; asynchronous active-high reset
//   rden         : read request from the consumer
//   wptr_gray    : write pointer (Gray), asynchronous to rclk
//   rdata_mem    : RAM read data, combinational from raddr
//   raddr        : RAM read address, taken straight from the pointer register
//   rptr_gray    : registered Gray read pointer, sent to the write domain
//   odata        : read data, updated one cycle after an accepted rden
//   rd_valid     : odata was updated on this edge
//   rd_empty     : registered empty flag
//   rd_count     : occupancy as seen from the read domain (never overstated)
//   rd_underflow : sticky; set by rden while empty, cleared only by reset
// -----------------------------------------------------------------------------
module afifo_rd_ctrl
    import afifo_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rden,
    input  logic [ADDRSIZE:0]   wptr_gray,
    input  logic [DATASIZE-1:0] rdata_mem,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic [DATASIZE-1:0] odata,
    output logic                rd_valid,
    output logic                rd_empty,
    output logic [ADDRSIZE:0]   rd_count,
    output logic                rd_underflow
);

    localparam int PTRW = ADDRSIZE + 1;

    logic [PTRW-1:0]     rptr_bin_q, rptr_bin_d;
    logic [PTRW-1:0]     rptr_gray_q, rptr_gray_d;
    logic                rd_empty_q, rd_empty_d;
    logic [PTRW-1:0]     rd_count_q, rd_count_d;
    logic [DATASIZE-1:0] odata_q, odata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_underflow_q, rd_underflow_d;

    logic [PTRW-1:0]     wq2_gray;
    logic [PTRW-1:0]     wq2_bin;
    logic                rd_fire;

    afifo_sync_w2r #(
        .WIDTH (PTRW)
    ) u_sync_w2r (
        .clk (rclk),
        .rst (rrst),
        .d_i (wptr_gray),
        .q_o (wq2_gray)
    );

    // Every next-state value uses the pre-edge synchronised write pointer.
    // A write that lands on the same edge becomes visible one cycle later,
    // so empty is conservative and is never deasserted falsely.
    always_comb begin
        rd_fire        = rden & ~rd_empty_q;
        rptr_bin_d     = rptr_bin_q + PTRW'(rd_fire);
        rptr_gray_d    = PTRW'(bin2gray(32'(rptr_bin_d)));
        wq2_bin        = PTRW'(gray2bin(32'(wq2_gray)));
        // Comparing the full Gray pointers, extra wrap bit included, tells
        // empty apart from full.
        rd_empty_d     = (rptr_gray_d == wq2_gray);
        // Modulo subtraction stays correct across pointer wrap. The result
        // reaches 2**ADDRSIZE when the FIFO is full.
        rd_count_d     = wq2_bin - rptr_bin_d;
        rd_underflow_d = rd_underflow_q | (rden & rd_empty_q);
        odata_d        = rd_fire ? rdata_mem : odata_q;
        rd_valid_d     = rd_fire;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rptr_bin_q     <= '0;
            rptr_gray_q    <= '0;
            rd_empty_q     <= 1'b1;
            rd_count_q     <= '0;
            odata_q        <= '0;
            rd_valid_q     <= 1'b0;
            rd_underflow_q <= 1'b0;
        end else begin
            rptr_bin_q     <= rptr_bin_d;
            rptr_gray_q    <= rptr_gray_d;
            rd_empty_q     <= rd_empty_d;
            rd_count_q     <= rd_count_d;
            odata_q        <= odata_d;
            rd_valid_q     <= rd_valid_d;
            rd_underflow_q <= rd_underflow_d;
        end
    end

    // NOTE: raddr comes straight from the pointer register, with no
    // rd_fire-dependent mux. RAM data for the word at the head is therefore
    // already valid when rden arrives, and a read can complete every cycle.
    assign raddr        = rptr_bin_q[ADDRSIZE-1:0];
    assign rptr_gray    = rptr_gray_q;
    assign rd_empty     = rd_empty_q;
    assign rd_count     = rd_count_q;
    assign odata        = odata_q;
    assign rd_valid     = rd_valid_q;
    assign rd_underflow = rd_underflow_q;

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_afifo_rd_ctrl
// Bench for afifo_rd_ctrl. The bench plays the write side: it owns the RAM and
// the write pointer. A transaction-level model tracks the words in the FIFO,
// how many of them the read domain can see yet, and the read position. Every
// accepted read pushes its expected word into a scoreboard queue. A monitor
// pops that queue whenever the DUT raises rd_valid and checks the status
// outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_afifo_rd_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int PW   = AW + 1;
    localparam int PMOD = 1 << PW;
    localparam int DEP  = 1 << AW;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          rden = 1'b0;
    logic [PW-1:0] wptr_gray = '0;
    logic [DW-1:0] rdata_mem;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr_gray;
    logic [DW-1:0] odata;
    logic          rd_valid;
    logic          rd_empty;
    logic [PW-1:0] rd_count;
    logic          rd_underflow;

    logic [DW-1:0] ram [DEP];

    int n_tests = 0;
    int n_fail  = 0;

    // Write-side state
    int            wr_ptr = 0;
    logic [DW-1:0] ref_q [$];

    // Reference model state
    int            m_rp    = 0;
    bit            m_empty = 1'b1;
    int            m_count = 0;
    bit            m_uf    = 1'b0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_odata = '0;
    int            seen_a  = 0;  // write count sampled on the previous edge
    int            seen_b  = 0;  // write count the reader may act on now
    logic [DW-1:0] exp_q [$];

    logic [PW-1:0] prev_gray = '0;

    always #5 rclk = ~rclk;

    assign rdata_mem = ram[raddr];

    afifo_rd_ctrl #(
        .DATASIZE (DW),
        .ADDRSIZE (AW)
    ) dut (
        .rclk         (rclk),
        .rrst         (rrst),
        .rden         (rden),
        .wptr_gray    (wptr_gray),
        .rdata_mem    (rdata_mem),
        .raddr        (raddr),
        .rptr_gray    (rptr_gray),
        .odata        (odata),
        .rd_valid     (rd_valid),
        .rd_empty     (rd_empty),
        .rd_count     (rd_count),
        .rd_underflow (rd_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v % PMOD);
        return b ^ (b >> 1);
    endfunction

    function automatic int occupancy();
        return (wr_ptr - m_rp + PMOD) % PMOD;
    endfunction

    // Write one word into the FIFO storage and publish the new write pointer.
    task automatic write_word(input logic [DW-1:0] d);
        ram[wr_ptr % DEP] = d;
        ref_q.push_back(d);
        wr_ptr            = (wr_ptr + 1) % PMOD;
        wptr_gray         = to_gray(wr_ptr);
    endtask

    // The write side is reset at the same moment as the reader.
    task automatic assert_reset();
        rrst      = 1'b1;
        rden      = 1'b0;
        wr_ptr    = 0;
        wptr_gray = '0;
        ref_q.delete();
    endtask

    // Reference model: a read succeeds if the reader believed the FIFO held
    // data before this edge. Writes become usable after two synchronising edges.
    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            m_rp    = 0;
            m_empty = 1'b1;
            m_count = 0;
            m_uf    = 1'b0;
            m_valid = 1'b0;
            m_odata = '0;
            seen_a  = 0;
            seen_b  = 0;
            exp_q.delete();
        end else begin
            m_valid = 1'b0;
            if (rden && m_empty) m_uf = 1'b1;
            if (rden && !m_empty && ref_q.size() > 0) begin
                m_odata = ref_q.pop_front();
                exp_q.push_back(m_odata);
                m_valid = 1'b1;
                m_rp    = (m_rp + 1) % PMOD;
            end
            m_empty = (m_rp == seen_b);
            m_count = (seen_b - m_rp + PMOD) % PMOD;
            seen_b  = seen_a;
            seen_a  = wr_ptr;
        end
    end

    // Monitor and scoreboard
    always @(negedge rclk) begin
        check("rd_empty", 32'(rd_empty), 32'(m_empty));
        check("rd_count", 32'(rd_count), 32'(m_count));
        check("rd_underflow", 32'(rd_underflow), 32'(m_uf));
        check("raddr", 32'(raddr), 32'(m_rp % DEP));
        check("rptr_gray", 32'(rptr_gray), 32'(to_gray(m_rp)));
        check("gray_one_bit_step", 32'($countones(rptr_gray ^ prev_gray) <= 1), 32'(1));
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("odata_hold", 32'(odata), 32'(m_odata));
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_valid_spurious", 32'(rd_valid), 32'(0));
            end else begin
                check("scoreboard_odata", 32'(odata), 32'(exp_q.pop_front()));
            end
        end
        prev_gray = rrst ? '0 : rptr_gray;
    end

    initial begin
        for (int i = 0; i < DEP; i++) ram[i] = '0;

        // Reset state, then a read attempt while empty
        assert_reset();
        repeat (3) @(negedge rclk);
        check("reset_rd_empty", 32'(rd_empty), 32'(1));
        check("reset_rd_count", 32'(rd_count), 32'(0));
        check("reset_raddr", 32'(raddr), 32'(0));
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        rrst = 1'b0;
        @(negedge rclk);
        rden = 1'b1;
        @(negedge rclk);
        rden = 1'b0;
        check("underflow_set", 32'(rd_underflow), 32'(1));
        check("underflow_ptr_still", 32'(rptr_gray), 32'(0));

        // One word: empty falls on the third edge, then the last-word read
        write_word(8'hA5);
        @(negedge rclk);
        check("vis_edge1_empty", 32'(rd_empty), 32'(1));
        @(negedge rclk);
        check("vis_edge2_empty", 32'(rd_empty), 32'(1));
        @(negedge rclk);
        check("vis_edge3_not_empty", 32'(rd_empty), 32'(0));
        rden = 1'b1;
        @(negedge rclk);
        rden = 1'b0;
        check("one_word_odata", 32'(odata), 32'(8'hA5));
        check("one_word_valid", 32'(rd_valid), 32'(1));
        check("one_word_empty", 32'(rd_empty), 32'(1));
        check("one_word_rptr_gray", 32'(rptr_gray), 32'(5'b00001));

        // Full FIFO after a fresh reset, drained at one word per cycle
        @(negedge rclk);
        #2 assert_reset();
        @(negedge rclk);
        #2 rrst = 1'b0;
        @(negedge rclk);
        for (int i = 0; i < DEP; i++) write_word(DW'(i));
        repeat (3) @(negedge rclk);
        check("full_rd_count", 32'(rd_count), 32'(DEP));
        check("full_not_empty", 32'(rd_empty), 32'(0));
        rden = 1'b1;
        repeat (DEP) @(negedge rclk);
        rden = 1'b0;
        check("drained_empty", 32'(rd_empty), 32'(1));
        check("drained_count", 32'(rd_count), 32'(0));

        // Read across the pointer wrap (31 -> 0)
        rden = 1'b1;
        for (int i = 0; i < 24; i++) begin
            write_word(DW'(8'h40 + i));
            @(negedge rclk);
        end
        repeat (6) @(negedge rclk);
        check("wrap_rptr_gray", 32'(rptr_gray), 32'(to_gray(40)));

        // rden held while empty, then a single write arrives
        repeat (4) @(negedge rclk);
        write_word(8'h77);
        repeat (6) @(negedge rclk);
        rden = 1'b0;
        check("held_rden_odata", 32'(odata), 32'(8'h77));

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 45 && occupancy() < DEP) write_word(DW'($urandom));
            rden = ($urandom_range(0, 99) < 50);
            @(negedge rclk);
        end

        // Drain, then reset in the middle of a burst with 7 words outstanding
        rden = 1'b1;
        repeat (24) @(negedge rclk);
        rden = 1'b0;
        for (int i = 0; i < 10; i++) write_word(DW'(8'hC0 + i));
        repeat (3) @(negedge rclk);
        rden = 1'b1;
        repeat (3) @(negedge rclk);
        check("pre_reset_count", 32'(rd_count), 32'(7));
        #2 assert_reset();
        #1;
        check("mid_reset_empty", 32'(rd_empty), 32'(1));
        check("mid_reset_count", 32'(rd_count), 32'(0));
        check("mid_reset_raddr", 32'(raddr), 32'(0));
        check("mid_reset_rptr_gray", 32'(rptr_gray), 32'(0));
        check("mid_reset_valid", 32'(rd_valid), 32'(0));
        check("mid_reset_odata", 32'(odata), 32'(0));
        check("mid_reset_underflow", 32'(rd_underflow), 32'(0));
        repeat (2) @(negedge rclk);
        #2 rrst = 1'b0;
        repeat (5) @(negedge rclk);
        check("post_reset_empty", 32'(rd_empty), 32'(1));

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
